load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_LIMIT, default 4096, byte addresses at or above it are out of range.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal
- req_signed  in  1  sign-extend loaded byte/halfword
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range, or illegal size
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory writes on rising clk
- mem_addr  out  32  word-aligned byte address to memory
- mem_wdata  out  32  full word to memory
- mem_rdata  in  32  combinational memory read data

Function
REQ-003 SHALL implement FSM states IDLE, LOAD_RD, RMW_RD, STORE_WR, RESP.
REQ-004 SHALL assert req_ready only in IDLE and accept a request on a rising edge with req_valid and req_ready both high, latching all req_* fields.
REQ-005 SHALL ignore req_valid while req_ready is low; no request is queued or dropped-with-response.
REQ-006 SHALL, on acceptance, go to RESP with resp_err=1 and perform no memory access if any of these hold: halfword with addr[0]=1; word with addr[1:0]!=0; size=11; addr >= ADDR_LIMIT.
REQ-007 SHALL otherwise go to LOAD_RD for loads, STORE_WR for word stores, or RMW_RD for byte/halfword stores.
REQ-008 SHALL drive mem_addr={addr[31:2],2'b00} in LOAD_RD, RMW_RD and STORE_WR, and drive 0 in all other states.
REQ-009 SHALL assert mem_read only in LOAD_RD and RMW_RD, and capture mem_rdata on the closing edge of that cycle.
REQ-010 SHALL assert mem_write only in STORE_WR, for exactly one cycle.
REQ-011 SHALL never assert mem_read and mem_write together.
REQ-012 SHALL use little-endian lanes: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1] (lane 0 = bits 15:0).
REQ-013 SHALL make loaded bytes and halfwords zero-extended, or sign-extended when req_signed=1; req_signed has no effect on words.
REQ-014 SHALL, in STORE_WR for a byte/halfword store, write the captured word with only the addressed lane replaced by the low bits of wdata.
REQ-015 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-016 SHALL have these latencies from the acceptance edge to the resp_valid cycle: error 1 cycle; load 2; word store 2; sub-word store 3.
REQ-017 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid is 0.

Reset
REQ-018 SHALL, when rst is asserted (asynchronously, in any state), force IDLE and drive req_ready=1 after release, with resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr and mem_wdata all 0.
REQ-019 SHALL abandon any in-flight operation on reset: no mem_write, no response, and the captured RMW word discarded.

Structure
REQ-020 SHALL place the state enum, size encodings (SIZE_B, SIZE_H, SIZE_W) and the default ADDR_LIMIT in shared package lsu_pkg.
REQ-021 SHALL implement lane extract/extend and lane merge in combinational sub-module lsu_lane_mux, instantiated once.

Verification
REQ-022 Word load: memory word at byte 0x0 = 32'h3DFBF0BE; load word @0x0 -> resp_valid 2 cycles after acceptance, resp_rdata=32'h3DFBF0BE, resp_err=0.
REQ-023 Signed byte load: same word; load byte signed @0x1 -> resp_rdata=32'hFFFFFFF0; unsigned -> 32'h000000F0.
REQ-024 Halfword store RMW: word @0x4 = 32'h11223344; store half @0x6 with wdata=32'h0000ABCD -> one mem_write with mem_wdata=32'hABCD3344, resp_valid on the 3rd cycle, mem_read high only in the cycle before the write.
REQ-025 Errors: word load @0x2, half store @0x3, size=11, and load @4096 -> each gives resp_err=1 after 1 cycle, mem_read=mem_write=0 throughout, resp_rdata=0.
REQ-026 Reset mid-RMW: assert rst during RMW_RD of a byte store -> no mem_write, no resp_valid, memory word unchanged, req_ready=1 after release.
REQ-027 Back-to-back: req_valid held high with two queued stores -> second accepted only in the IDLE cycle after the first RESP, with mem_write pulses separated by at least 2 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, size encodings and defaults for the load/store unit.
// Imported by the top level and the lane multiplexer.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_RD  = 3'd1,
    RMW_RD   = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int unsigned LSU_ADDR_LIMIT = 4096;

  // Size 11 is reported as misaligned so one flag covers both error kinds.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  align_err = 1'b0;
      SIZE_H:  align_err = addr_lo[0];
      SIZE_W:  align_err = (addr_lo != 2'b00);
      default: align_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; word sizes pass straight through.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] word_sh_b;
  logic [31:0] word_sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh   = {lane, 3'b000};
  assign half_sh   = {lane[1], 4'b0000};
  assign word_sh_b = word >> byte_sh;
  assign word_sh_h = word >> half_sh;
  assign byte_v    = word_sh_b[7:0];
  assign half_v    = word_sh_h[15:0];

  always_comb begin
    load_data = word;
    merged    = wdata;
    case (size)
      SIZE_B: begin
        load_data = {{24{is_signed & byte_v[7]}}, byte_v};
        merged    = (word & ~(32'h0000_00FF << byte_sh)) | ({24'd0, wdata[7:0]} << byte_sh);
      end
      SIZE_H: begin
        load_data = {{16{is_signed & half_v[15]}}, half_v};
        merged    = (word & ~(32'h0000_FFFF << half_sh)) | ({16'd0, wdata[15:0]} << half_sh);
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with byte/halfword/word accesses to a
// word-wide memory; sub-word stores use a read-modify-write sequence.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = LSU_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept  = req_valid && (state == IDLE);
  assign req_err = align_err(req_size, req_addr[1:0]) || (req_addr >= 32'(ADDR_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are latched at acceptance; the memory word is captured
  // at the end of either read state and cleared by reset so no stale RMW data survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      size_q   <= SIZE_B;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
      end
      if (state == LOAD_RD || state == RMW_RD) begin
        word_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                 state_next = RESP;
          else if (!req_write)         state_next = LOAD_RD;
          else if (req_size == SIZE_W) state_next = STORE_WR;
          else                         state_next = RMW_RD;
        end
      end
      LOAD_RD: begin
        mem_read   = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        state_next = RESP;
      end
      RMW_RD: begin
        mem_read   = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        state_next = STORE_WR;
      end
      STORE_WR: begin
        mem_write  = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = merged;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || write_q) ? 32'd0 : load_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  lsu_lane_mux u_lane_mux (
    .word      (word_q),
    .wdata     (wdata_q),
    .lane      (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .load_data (load_data),
    .merged    (merged)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a small word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;
  int overlap_cnt = 0;

  logic [31:0] mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'd0;
  logic [31:0] poke_val = 32'd0;

  int          r_lat, r_reads, r_writes, r_read_cyc, r_write_cyc, r_leak;
  logic [31:0] r_rdata, r_wdata, r_read_addr;
  logic        r_err;

  load_store_unit #(.ADDR_LIMIT(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_cnt++;
  end

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_idx = idx;
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Issues one request from IDLE and records what happens until the response (8-cycle bound).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    r_lat = 0; r_reads = 0; r_writes = 0; r_read_cyc = 0; r_write_cyc = 0; r_leak = 0;
    r_rdata = 32'hDEAD_0000; r_wdata = 32'd0; r_read_addr = 32'hFFFF_FFFF; r_err = 1'bx;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_read) begin r_reads++; r_read_cyc = cyc; r_read_addr = mem_addr; end
      if (mem_write) begin r_writes++; r_write_cyc = cyc; r_wdata = mem_wdata; end
      if (resp_valid) begin
        r_lat = cyc; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
        r_leak++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp: got %h/%b expected 0/0", resp_rdata, resp_err); end
    tests_run++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_en: got %b%b expected 00", mem_read, mem_write); end
    tests_run++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_load();
    poke(10'd0, 32'h3DFB_F0BE);
    poke(10'd2, 32'h0BAD_CAFE);
    run_req(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0);
    tests_run++; if (r_lat !== 2) begin tests_failed++; $display("[TB] FAIL word_load_latency: got %0d expected 2", r_lat); end
    tests_run++; if (r_rdata !== 32'h3DFB_F0BE) begin tests_failed++; $display("[TB] FAIL word_load_rdata: got %h expected 3dfbf0be", r_rdata); end
    tests_run++; if (r_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL word_load_err: got %b expected 0", r_err); end
    tests_run++; if (r_reads !== 1 || r_writes !== 0 || r_read_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL word_load_mem: reads %0d writes %0d addr %h expected 1 0 0", r_reads, r_writes, r_read_addr); end
    run_req(1'b0, SIZE_W, 1'b1, 32'h8, 32'h0);
    tests_run++; if (r_rdata !== 32'h0BAD_CAFE || r_read_addr !== 32'h8) begin tests_failed++; $display("[TB] FAIL word_load_signed_0x8: got %h @%h expected 0badcafe @8", r_rdata, r_read_addr); end
    poke(10'd1023, 32'h1234_5678);
    run_req(1'b0, SIZE_W, 1'b0, 32'hFFC, 32'h0);
    tests_run++; if (r_err !== 1'b0 || r_rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL word_load_last: got %h err %b expected 12345678 err 0", r_rdata, r_err); end
  endtask

  task automatic test_subword_load();
    logic [1:0]  sz [8];
    logic        sg [8];
    logic [31:0] ad [8];
    logic [31:0] ex [8];
    sz = '{SIZE_B, SIZE_B, SIZE_B, SIZE_B, SIZE_H, SIZE_H, SIZE_H, SIZE_B};
    sg = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0};
    ad = '{32'h1,  32'h1,  32'h0,  32'h3,  32'h2,  32'h0,  32'h0,  32'h2};
    ex = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_FFBE, 32'h0000_003D,
           32'h0000_3DFB, 32'hFFFF_F0BE, 32'h0000_F0BE, 32'h0000_00FB};
    for (int i = 0; i < 8; i++) begin
      run_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
      tests_run++;
      if (r_rdata !== ex[i] || r_lat !== 2 || r_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL subword_load_%0d: got %h lat %0d err %b expected %h lat 2 err 0", i, r_rdata, r_lat, r_err, ex[i]);
      end
    end
  endtask

  task automatic test_store();
    poke(10'd1, 32'h1122_3344);
    run_req(1'b1, SIZE_H, 1'b0, 32'h6, 32'h0000_ABCD);
    tests_run++; if (r_writes !== 1 || r_wdata !== 32'hABCD_3344) begin tests_failed++; $display("[TB] FAIL half_store_write: writes %0d data %h expected 1 abcd3344", r_writes, r_wdata); end
    tests_run++; if (r_lat !== 3) begin tests_failed++; $display("[TB] FAIL half_store_latency: got %0d expected 3", r_lat); end
    tests_run++; if (r_reads !== 1 || r_read_cyc !== 1 || r_write_cyc !== 2) begin tests_failed++; $display("[TB] FAIL half_store_order: reads %0d rd_cyc %0d wr_cyc %0d expected 1 1 2", r_reads, r_read_cyc, r_write_cyc); end
    tests_run++; if (r_rdata !== 32'd0 || r_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL half_store_resp: got %h err %b expected 0 err 0", r_rdata, r_err); end
    tests_run++; if (mem[1] !== 32'hABCD_3344) begin tests_failed++; $display("[TB] FAIL half_store_mem: got %h expected abcd3344", mem[1]); end
    run_req(1'b1, SIZE_B, 1'b0, 32'h5, 32'hFFFF_FF77);
    tests_run++; if (mem[1] !== 32'hABCD_7744) begin tests_failed++; $display("[TB] FAIL byte_store_mem: got %h expected abcd7744", mem[1]); end
    run_req(1'b1, SIZE_W, 1'b0, 32'h8, 32'hDEAD_BEEF);
    tests_run++; if (r_lat !== 2 || r_reads !== 0 || r_writes !== 1 || r_write_cyc !== 1) begin tests_failed++; $display("[TB] FAIL word_store_timing: lat %0d reads %0d writes %0d wr_cyc %0d expected 2 0 1 1", r_lat, r_reads, r_writes, r_write_cyc); end
    tests_run++; if (mem[2] !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL word_store_mem: got %h expected deadbeef", mem[2]); end
  endtask

  task automatic test_errors();
    logic        wr [4];
    logic [1:0]  sz [4];
    logic [31:0] ad [4];
    wr = '{1'b0,   1'b1,   1'b0,  1'b0};
    sz = '{SIZE_W, SIZE_H, 2'b11, SIZE_W};
    ad = '{32'h2,  32'h3,  32'h0, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      run_req(wr[i], sz[i], 1'b0, ad[i], 32'h5555_5555);
      tests_run++;
      if (r_lat !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0 || r_reads !== 0 || r_writes !== 0 || r_leak !== 0) begin
        tests_failed++;
        $display("[TB] FAIL error_case_%0d: lat %0d err %b rdata %h reads %0d writes %0d leak %0d expected 1 1 0 0 0 0",
                 i, r_lat, r_err, r_rdata, r_reads, r_writes, r_leak);
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int writes = 0;
    int resps = 0;
    poke(10'd3, 32'hCAFE_F00D);
    @(negedge clk);
    req_write = 1'b1; req_size = SIZE_B; req_signed = 1'b0; req_addr = 32'hC; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tests_run++; if (mem_read !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmw_rd_before_reset: mem_read %b expected 1", mem_read); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (mem_read !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmw_async_reset: mem_read %b ready %b expected 0 1", mem_read, req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (mem_write) writes++;
      if (resp_valid) resps++;
    end
    tests_run++; if (writes !== 0 || resps !== 0) begin tests_failed++; $display("[TB] FAIL rmw_reset_quiet: writes %0d resps %0d expected 0 0", writes, resps); end
    tests_run++; if (mem[3] !== 32'hCAFE_F00D) begin tests_failed++; $display("[TB] FAIL rmw_reset_mem: got %h expected cafef00d", mem[3]); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmw_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int w1 = 0, w2 = 0, wc = 0, rc = 0, r1 = 0, r2 = 0, ready_cyc = 0;
    logic seen = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_size = SIZE_W; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'hA1A1_A1A1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 begin req_addr = 32'h14; req_wdata = 32'hB2B2_B2B2; end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (mem_write) begin wc++; if (wc == 1) w1 = cyc; else w2 = cyc; end
      if (resp_valid) begin rc++; if (rc == 1) r1 = cyc; else r2 = cyc; end
      if (req_ready && !seen) begin seen = 1'b1; ready_cyc = cyc; end
      else if (seen) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    tests_run++; if (ready_cyc !== 3) begin tests_failed++; $display("[TB] FAIL b2b_second_accept: ready cycle %0d expected 3", ready_cyc); end
    tests_run++; if (wc !== 2 || w1 !== 1 || w2 !== 4) begin tests_failed++; $display("[TB] FAIL b2b_writes: count %0d at %0d,%0d expected 2 at 1,4", wc, w1, w2); end
    tests_run++; if (rc !== 2 || r1 !== 2 || r2 !== 5) begin tests_failed++; $display("[TB] FAIL b2b_resps: count %0d at %0d,%0d expected 2 at 2,5", rc, r1, r2); end
    tests_run++; if (mem[4] !== 32'hA1A1_A1A1 || mem[5] !== 32'hB2B2_B2B2) begin tests_failed++; $display("[TB] FAIL b2b_mem: got %h,%h expected a1a1a1a1,b2b2b2b2", mem[4], mem[5]); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    tests_run++;
    if (overlap_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL read_write_overlap: got %0d cycles expected 0", overlap_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
